// File: rtl/btle_pkg.sv
// Shared definitions for the BLE TX datapath blocks.
//   state_t        : serializer FSM encoding (S_IDLE, S_FETCH, S_SHIFT, S_DONE)
//   BLE_LSB_FIRST  : BLE air order sends bit 0 of every octet first
package btle_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam bit BLE_LSB_FIRST = 1'b1;

endpackage : btle_pkg

// File: rtl/dpram_bit_serializer.sv
// dpram_bit_serializer
//   Reads num_byte words from buffer addresses 0..num_byte-1 and streams them
//   out one bit at a time under a valid/ready handshake.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : job request, honoured only in IDLE
//   num_byte        : number of words in the job, latched on accepted start
//   read_address    : registered buffer read address
//   read_data       : buffer word, combinational from read_address
//   bit_out         : serial data bit
//   bit_valid       : bit_out valid
//   bit_ready       : downstream accepts when bit_valid & bit_ready
//   busy            : high from accepted start until the last bit is accepted
//   done            : one-cycle completion pulse (also for an empty job)
import btle_pkg::*;

module dpram_bit_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 11,
    parameter bit LSB_FIRST     = BLE_LSB_FIRST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] num_byte,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic                     bit_out,
    output logic                     bit_valid,
    input  logic                     bit_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR = ADDRESS_WIDTH'(1);

    state_t                   state_q,     state_d;
    logic [ADDRESS_WIDTH-1:0] len_q,       len_d;
    logic [ADDRESS_WIDTH-1:0] word_cnt_q,  word_cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]    shreg_q,     shreg_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic                     bit_valid_q, bit_valid_d;
    logic                     busy_q,      busy_d;
    logic                     done_q,      done_d;
    logic [DATA_WIDTH-1:0]    shreg_next_s;

    // Shift the consumed bit out so the next one lands on the output tap
    always_comb begin
        if (LSB_FIRST) begin
            shreg_next_s = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        end else begin
            shreg_next_s = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and registered-output computation for the job FSM
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        bit_valid_d = bit_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                bit_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    len_d      = num_byte;
                    word_cnt_d = '0;
                    addr_d     = '0;
                    if (num_byte != '0) begin
                        state_d = S_FETCH;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty job: report completion without ever going busy
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // read_address has been stable since the previous edge
                shreg_d     = read_data;
                bit_cnt_d   = '0;
                bit_valid_d = 1'b1;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_ready) begin
                    shreg_d   = shreg_next_s;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_valid_d = 1'b0;
                        if (word_cnt_q == (len_q - ONE_ADDR)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            word_cnt_d = word_cnt_q + ONE_ADDR;
                            addr_d     = addr_q + ONE_ADDR;
                            state_d    = S_FETCH;
                        end
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    // Hold: valid and data stay put until the transfer happens
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                bit_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                bit_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything, mid-job included
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            addr_q      <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign read_address = addr_q;
    assign bit_out      = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
    assign bit_valid    = bit_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule : dpram_bit_serializer
